conv_layer_mc: RTL and testbench

//   Parametrised multi-channel 2-D convolution stage (successor of the single-kernel conv1 stage).

---
 rtl/conv_layer_mc.sv | 166 ++++++++++++++++
 tb/tb_conv_layer_mc.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_mc.sv
// Multi-channel KxK convolution stage: line-buffered window, OUT_CH parallel kernels,
// ReLU / arithmetic shift / unsigned saturation, fixed three-stage pipeline.
module conv_layer_mc #(
    parameter int IMG_W  = 28,
    parameter int K      = 5,
    parameter int OUT_CH = 6,
    parameter int IN_W   = 8,
    parameter int W_W    = 16,
    parameter int ACC_W  = 32,
    parameter int SHIFT  = 0,
    parameter int OUT_W  = 16,
    localparam int CH_W  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
    localparam int IDX_W = $clog2(K * K + 1),
    localparam int POS_W = $clog2(IMG_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [IN_W-1:0]         cnn_data_in,
    input  logic                    cnn_data_in_valid,
    input  logic                    img_in_en,
    input  logic                    w_wr_en,
    input  logic [CH_W-1:0]         w_wr_ch,
    input  logic [IDX_W-1:0]        w_wr_idx,
    input  logic signed [W_W-1:0]   w_wr_data,
    output logic [OUT_CH*OUT_W-1:0] cnn_data_out,
    output logic                    cnn_data_out_valid,
    output logic [POS_W-1:0]        out_x,
    output logic [POS_W-1:0]        out_y,
    output logic                    frame_done
);
    localparam int KK     = K * K;
    localparam int PROD_W = IN_W + W_W + 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(IMG_W - 1);
    localparam logic [POS_W-1:0] WIN_M1   = POS_W'(K - 1);

    logic                    accept;
    logic                    wr_ok;
    logic [POS_W-1:0]        col_q, row_q;
    logic signed [W_W-1:0]   wt_q   [OUT_CH][KK];
    logic signed [W_W-1:0]   bias_q [OUT_CH];
    logic [IN_W-1:0]         lb_q   [K-1][IMG_W];
    logic [IN_W-1:0]         win_q  [K][K];
    logic                    s1_valid_q, s1_done_q;
    logic [POS_W-1:0]        s1_x_q, s1_y_q;
    logic signed [PROD_W-1:0] prod_q [OUT_CH][KK];
    logic                    s2_valid_q, s2_done_q;
    logic [POS_W-1:0]        s2_x_q, s2_y_q;
    logic signed [ACC_W-1:0] sum [OUT_CH];
    logic signed [ACC_W-1:0] shf [OUT_CH];
    logic [OUT_CH*OUT_W-1:0] out_d;

    assign accept = cnn_data_in_valid & img_in_en;
    assign wr_ok  = w_wr_en & ~img_in_en & (int'(w_wr_ch) < OUT_CH) & (int'(w_wr_idx) <= KK);

    // Dropping img_in_en aborts the frame by rewinding the raster position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (!img_in_en) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_q == LAST_POS) begin
                col_q <= '0;
                row_q <= (row_q == LAST_POS) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < OUT_CH; ch++) begin
                bias_q[ch] <= '0;
                for (int i = 0; i < KK; i++) wt_q[ch][i] <= '0;
            end
        end else if (wr_ok) begin
            if (int'(w_wr_idx) == KK) bias_q[w_wr_ch] <= w_wr_data;
            else                      wt_q[w_wr_ch][w_wr_idx] <= w_wr_data;
        end
    end

    // Line buffer k holds the row k+1 above the incoming one; window row 0 is the oldest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < K - 1; k++)
                for (int x = 0; x < IMG_W; x++) lb_q[k][x] <= '0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) win_q[r][c] <= '0;
        end else if (accept) begin
            lb_q[0][col_q] <= cnn_data_in;
            for (int k = 1; k < K - 1; k++) lb_q[k][col_q] <= lb_q[k-1][col_q];
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K - 1; c++) win_q[r][c] <= win_q[r][c+1];
            for (int r = 0; r < K - 1; r++) win_q[r][K-1] <= lb_q[K-2-r][col_q];
            win_q[K-1][K-1] <= cnn_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_done_q  <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
        end else begin
            s1_valid_q <= accept && (col_q >= WIN_M1) && (row_q >= WIN_M1);
            s1_done_q  <= accept && (col_q == LAST_POS) && (row_q == LAST_POS);
            s1_x_q     <= col_q - WIN_M1;
            s1_y_q     <= row_q - WIN_M1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < OUT_CH; ch++)
                for (int i = 0; i < KK; i++) prod_q[ch][i] <= '0;
            s2_valid_q <= 1'b0;
            s2_done_q  <= 1'b0;
            s2_x_q     <= '0;
            s2_y_q     <= '0;
        end else begin
            for (int ch = 0; ch < OUT_CH; ch++)
                for (int i = 0; i < KK; i++)
                    prod_q[ch][i] <= PROD_W'($signed({1'b0, win_q[i/K][i%K]}))
                                     * PROD_W'(wt_q[ch][i]);
            s2_valid_q <= s1_valid_q;
            s2_done_q  <= s1_done_q;
            s2_x_q     <= s1_x_q;
            s2_y_q     <= s1_y_q;
        end
    end

    always_comb begin
        out_d = '0;
        for (int ch = 0; ch < OUT_CH; ch++) begin
            sum[ch] = ACC_W'(bias_q[ch]);
            for (int i = 0; i < KK; i++) sum[ch] = sum[ch] + ACC_W'(prod_q[ch][i]);
            shf[ch] = sum[ch][ACC_W-1] ? '0 : (sum[ch] >>> SHIFT);
            if (|shf[ch][ACC_W-1:OUT_W]) out_d[ch*OUT_W +: OUT_W] = '1;
            else                         out_d[ch*OUT_W +: OUT_W] = shf[ch][OUT_W-1:0];
        end
    end

    // Data and coordinates hold their last value between output pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnn_data_out       <= '0;
            cnn_data_out_valid <= 1'b0;
            out_x              <= '0;
            out_y              <= '0;
            frame_done         <= 1'b0;
        end else begin
            cnn_data_out_valid <= s2_valid_q;
            frame_done         <= s2_done_q;
            if (s2_valid_q) begin
                cnn_data_out <= out_d;
                out_x        <= s2_x_q;
                out_y        <= s2_y_q;
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_mc.sv
// Bench for conv_layer_mc: frame-level table of scenarios checked against a direct
// convolution model, plus abort and mid-frame reset sequences.
module tb_conv_layer_mc;
    localparam int IMG_W  = 28;
    localparam int K      = 5;
    localparam int OUT_CH = 6;
    localparam int IN_W   = 8;
    localparam int W_W    = 16;
    localparam int ACC_W  = 32;
    localparam int SHIFT  = 0;
    localparam int OUT_W  = 16;
    localparam int CH_W   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam int IDX_W  = $clog2(K * K + 1);
    localparam int POS_W  = $clog2(IMG_W);
    localparam int KK     = K * K;
    localparam int OW     = IMG_W - K + 1;
    localparam int NPIX   = IMG_W * IMG_W;
    localparam int DW     = OUT_CH * OUT_W;

    logic             clk;
    logic             rst_n;
    logic [IN_W-1:0]  cnn_data_in;
    logic             cnn_data_in_valid;
    logic             img_in_en;
    logic             w_wr_en;
    logic [CH_W-1:0]  w_wr_ch;
    logic [IDX_W-1:0] w_wr_idx;
    logic [W_W-1:0]   w_wr_data;
    logic [DW-1:0]    cnn_data_out;
    logic             cnn_data_out_valid;
    logic [POS_W-1:0] out_x;
    logic [POS_W-1:0] out_y;
    logic             frame_done;

    conv_layer_mc #(
        .IMG_W(IMG_W), .K(K), .OUT_CH(OUT_CH), .IN_W(IN_W), .W_W(W_W),
        .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cnn_data_in(cnn_data_in),
        .cnn_data_in_valid(cnn_data_in_valid), .img_in_en(img_in_en),
        .w_wr_en(w_wr_en), .w_wr_ch(w_wr_ch), .w_wr_idx(w_wr_idx), .w_wr_data(w_wr_data),
        .cnn_data_out(cnn_data_out), .cnn_data_out_valid(cnn_data_out_valid),
        .out_x(out_x), .out_y(out_y), .frame_done(frame_done)
    );

    typedef struct { int x; int y; bit done; logic [DW-1:0] data; int cyc; } rec_t;
    typedef struct {
        int pat; int wmode; int gap; int count; bit chk_first; logic [DW-1:0] first;
    } vec_t;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   rd_idx = 0;
    int   present_cyc = 0;
    int   last_n_got = 0;
    logic [DW-1:0] first_data;
    rec_t got_q[$];
    rec_t exp_q[$];
    rec_t mon_rec;
    int   img [IMG_W][IMG_W];
    int   mw [OUT_CH][KK];
    int   mb [OUT_CH];
    vec_t vecs [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cnn_data_out_valid) begin
            mon_rec.x    = int'(out_x);
            mon_rec.y    = int'(out_y);
            mon_rec.done = frame_done;
            mon_rec.data = cnn_data_out;
            mon_rec.cyc  = cyc;
            got_q.push_back(mon_rec);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] ref_px(input int ch, input int oy, input int ox);
        longint acc;
        longint maxv;
        maxv = (longint'(1) << OUT_W) - 1;
        acc  = mb[ch];
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                acc += longint'(img[oy+r][ox+c]) * mw[ch][r*K+c];
        if (acc < 0) acc = 0;
        acc = acc >>> SHIFT;
        if (acc > maxv) acc = maxv;
        return acc[OUT_W-1:0];
    endfunction

    // Outputs whose last window pixel lies within the first npix pixels, in raster order.
    task automatic build_expected(input int npix);
        rec_t e;
        exp_q.delete();
        for (int oy = 0; oy < OW; oy++)
            for (int ox = 0; ox < OW; ox++)
                if ((oy + K - 1) * IMG_W + ox + K - 1 < npix) begin
                    e.x = ox; e.y = oy; e.cyc = 0;
                    e.done = (ox == OW - 1) && (oy == OW - 1);
                    e.data = '0;
                    for (int ch = 0; ch < OUT_CH; ch++) e.data[ch*OUT_W +: OUT_W] = ref_px(ch, oy, ox);
                    exp_q.push_back(e);
                end
    endtask

    task automatic set_image(input int pat);
        for (int y = 0; y < IMG_W; y++)
            for (int x = 0; x < IMG_W; x++)
                case (pat)
                    0:       img[y][x] = 1;
                    1:       img[y][x] = (y * IMG_W + x) & 255;
                    2:       img[y][x] = 255;
                    default: img[y][x] = int'($urandom_range(255));
                endcase
    endtask

    task automatic wr(input int ch, input int idx, input int val);
        w_wr_en = 1'b1; w_wr_ch = CH_W'(ch); w_wr_idx = IDX_W'(idx); w_wr_data = W_W'(val);
        @(posedge clk); #1;
        w_wr_en = 1'b0;
    endtask

    // mode 4 only zeroes the model, leaving the DUT as reset left it.
    task automatic set_weights(input int mode);
        img_in_en = 1'b0;
        cnn_data_in_valid = 1'b0;
        @(posedge clk); #1;
        for (int ch = 0; ch < OUT_CH; ch++) begin
            mb[ch] = 0;
            for (int i = 0; i < KK; i++) begin
                case (mode)
                    0:       mw[ch][i] = 1;
                    2:       mw[ch][i] = (ch == 0) ? 32767 : (ch == 1) ? -32768 : 0;
                    3:       mw[ch][i] = int'($urandom_range(80)) - 40;
                    default: mw[ch][i] = 0;
                endcase
            end
            if (mode == 3) mb[ch] = int'($urandom_range(40000)) - 20000;
        end
        if (mode == 1) begin
            mw[0][2*K+2] = 1;
            mb[1] = -5;
            mb[2] = 300;
        end
        if (mode != 4) begin
            for (int ch = 0; ch < OUT_CH; ch++) begin
                for (int i = 0; i < KK; i++) wr(ch, i, mw[ch][i]);
                wr(ch, KK, mb[ch]);
            end
            wr(OUT_CH, 0, 16'h1234);
            wr(0, KK + 1, 16'h0777);
        end
    endtask

    task automatic send_pixels(input int npix, input int gap);
        for (int i = 0; i < npix; i++) begin
            while ($urandom_range(99) < gap) begin
                cnn_data_in_valid = 1'b0;
                cnn_data_in = IN_W'($urandom_range(255));
                @(posedge clk); #1;
            end
            cnn_data_in = IN_W'(img[i / IMG_W][i % IMG_W]);
            cnn_data_in_valid = 1'b1;
            if (i == (K - 1) * IMG_W + K - 1) present_cyc = cyc;
            @(posedge clk); #1;
        end
        cnn_data_in_valid = 1'b0;
    endtask

    task automatic compare_frame(input string tag);
        int n_got;
        int n_cmp;
        rec_t g;
        rec_t e;
        n_got = got_q.size() - rd_idx;
        last_n_got = n_got;
        check({tag, "_count"}, n_got, exp_q.size());
        n_cmp = (n_got < exp_q.size()) ? n_got : exp_q.size();
        for (int i = 0; i < n_cmp; i++) begin
            g = got_q[rd_idx + i];
            e = exp_q[i];
            check({tag, "_data"}, g.data, e.data);
            check({tag, "_pos_done"}, (g.y * 64 + g.x) * 2 + int'(g.done),
                  (e.y * 64 + e.x) * 2 + int'(e.done));
        end
        rd_idx += n_got;
    endtask

    task automatic run_frame(input string tag, input int gap, input int npix);
        int lat;
        build_expected(npix);
        img_in_en = 1'b1;
        send_pixels(npix, gap);
        repeat (6) @(posedge clk);
        #1;
        lat = (got_q.size() > rd_idx) ? got_q[rd_idx].cyc - present_cyc : -1;
        first_data = (got_q.size() > rd_idx) ? got_q[rd_idx].data : '1;
        check({tag, "_latency"}, lat, 3);
        compare_frame(tag);
    endtask

    initial begin
        int abort_cyc;
        int resid;
        vecs[0] = '{0, 0, 0,  576, 1'b1, {6{16'd25}}};
        vecs[1] = '{1, 1, 0,  576, 1'b1, {16'd0, 16'd0, 16'd0, 16'd300, 16'd0, 16'd58}};
        vecs[2] = '{2, 2, 0,  576, 1'b1, {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd65535}};
        vecs[3] = '{1, 1, 50, 576, 1'b1, {16'd0, 16'd0, 16'd0, 16'd300, 16'd0, 16'd58}};
        vecs[4] = '{3, 3, 25, 576, 1'b0, '0};

        rst_n = 1'b0; cnn_data_in = '0; cnn_data_in_valid = 1'b0; img_in_en = 1'b0;
        w_wr_en = 1'b0; w_wr_ch = '0; w_wr_idx = '0; w_wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", cnn_data_out, 0);
        check("reset_valid", cnn_data_out_valid, 0);
        check("reset_xy", {out_y, out_x}, 0);
        check("reset_done", frame_done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            set_image(vecs[v].pat);
            set_weights(vecs[v].wmode);
            run_frame($sformatf("vec%0d", v), vecs[v].gap, NPIX);
            check($sformatf("vec%0d_count_tbl", v), last_n_got, vecs[v].count);
            if (vecs[v].chk_first) check($sformatf("vec%0d_first", v), first_data, vecs[v].first);
        end

        // Abort after 300 pixels with a weight write attempted during the frame.
        set_image(1);
        set_weights(1);
        build_expected(300);
        img_in_en = 1'b1;
        w_wr_en = 1'b1; w_wr_ch = '0; w_wr_idx = IDX_W'(2 * K + 2); w_wr_data = W_W'(100);
        send_pixels(300, 0);
        img_in_en = 1'b0;
        w_wr_en = 1'b0;
        abort_cyc = cyc;
        repeat (6) @(posedge clk);
        #1;
        resid = 0;
        for (int i = rd_idx; i < got_q.size(); i++) if (got_q[i].cyc >= abort_cyc) resid++;
        check("abort_residual_le3", resid <= 3, 1);
        compare_frame("abort");
        run_frame("restart", 0, NPIX);

        // Asynchronous reset mid-frame, then weights must read back as cleared.
        set_image(1);
        set_weights(1);
        img_in_en = 1'b1;
        send_pixels(200, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_data", cnn_data_out, 0);
        check("midrst_valid", cnn_data_out_valid, 0);
        check("midrst_xy", {out_y, out_x}, 0);
        check("midrst_done", frame_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_idx = got_q.size();
        set_weights(4);
        run_frame("after_rst_zero", 0, NPIX);
        set_weights(1);
        run_frame("after_rst_reload", 0, NPIX);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
